// File: rtl/adc_sample_buffer_pkg.sv
// Shared register map, entry layout and bit positions for the ADC sample buffer.
// Entries are {timestamp, channel, sample} packed into one 32-bit FIFO word.
package adc_buf_pkg;

   localparam logic [2:0] REG_CTRL   = 3'd0;
   localparam logic [2:0] REG_STATUS = 3'd1;
   localparam logic [2:0] REG_DATA   = 3'd2;
   localparam logic [2:0] REG_WMARK  = 3'd3;
   localparam logic [2:0] REG_IRQ    = 3'd4;
   localparam logic [2:0] REG_DROP   = 3'd5;

   localparam int TS_LSB = 18;
   localparam int CH_LSB = 16;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_FLUSH    = 1;
   localparam int CTRL_MASK_LSB = 4;

   localparam int IRQ_WM_IE  = 0;
   localparam int IRQ_OVF_IE = 1;
   localparam int IRQ_WM_ST  = 16;
   localparam int IRQ_OVF_ST = 17;

   localparam int ST_EMPTY    = 8;
   localparam int ST_FULL     = 9;
   localparam int ST_LAST_LSB = 10;

   function automatic logic [31:0] make_entry(input logic [13:0] ts, input logic [1:0] ch,
                                              input logic [15:0] data);
      return (32'(ts) << TS_LSB) | (32'(ch) << CH_LSB) | 32'(data);
   endfunction

endpackage

// File: rtl/adc_sample_buffer_if.sv
// Wishbone classic slave bus bundle for the ADC sample buffer.
interface adc_sample_buffer_if;
   import adc_buf_pkg::*;

   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic        wb_we_i;
   logic [3:0]  wb_sel_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_ack_o;
   logic        wb_err_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_cyc_i, wb_stb_i,
      input  wb_dat_o, wb_ack_o, wb_err_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_cyc_i, wb_stb_i,
      output wb_dat_o, wb_ack_o, wb_err_o
   );

endinterface

// File: rtl/adc_sample_buffer_fifo.sv
// Synchronous FIFO with combinational head read; pointers carry an extra wrap bit.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level   = wr_ptr - rd_ptr;
   assign rdata   = mem[rd_ptr[AW-1:0]];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/adc_sample_buffer.sv
// ADC sample buffer: per-channel pending slots drained by fixed priority into a FIFO,
// with a Wishbone register file, timestamping, drop tracking and watermark interrupt.
module adc_sample_buffer
   import adc_buf_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int TS_W  = 14
) (
   input  logic                      clk,
   input  logic                      rst_n,
   adc_sample_buffer_if.slave        bus,
   input  logic [15:0]               ch0_data,
   input  logic [15:0]               ch1_data,
   input  logic [15:0]               ch2_data,
   input  logic [15:0]               ch3_data,
   input  logic [3:0]                data_valid,
   output logic                      irq,
   output logic [$clog2(DEPTH):0]    fifo_level
);
   logic            en;
   logic [3:0]      ch_mask;
   logic [6:0]      wmark;
   logic            wm_ie, ovf_ie, wm_st, ovf_st;
   logic [3:0]      drop;
   logic [1:0]      last_ch;
   logic [TS_W-1:0] ts;
   logic [3:0]      slot_full;
   logic [31:0]     slot_data [4];
   logic [15:0]     ch_data [4];

   logic        access, wr, rd, flush, pop, push, has_pending, wm_hit;
   logic [2:0]  addr;
   logic [1:0]  drain_idx, w1c;
   logic [3:0]  cap, drained, new_drop;
   logic [31:0] fifo_rdata, rd_mux;
   logic        fifo_full, fifo_empty;
   logic        unused_bits;

   assign ch_data[0] = ch0_data;
   assign ch_data[1] = ch1_data;
   assign ch_data[2] = ch2_data;
   assign ch_data[3] = ch3_data;

   assign access = bus.wb_cyc_i & bus.wb_stb_i & ~bus.wb_ack_o;
   assign wr     = access & bus.wb_we_i;
   assign rd     = access & ~bus.wb_we_i;
   assign addr   = bus.wb_adr_i[4:2];
   assign flush  = wr && (addr == REG_CTRL) && bus.wb_dat_i[CTRL_FLUSH];
   assign pop    = rd && (addr == REG_DATA) && !fifo_empty;
   assign w1c    = (wr && addr == REG_IRQ) ? bus.wb_dat_i[IRQ_OVF_ST:IRQ_WM_ST] : 2'b00;
   assign wm_hit = (wmark != 7'd0) && (7'(fifo_level) >= wmark);
   assign irq    = ((wm_st | wm_hit) & wm_ie) | (ovf_st & ovf_ie);

   assign bus.wb_err_o = 1'b0;
   assign unused_bits  = ^{bus.wb_sel_i, bus.wb_adr_i[31:5], bus.wb_adr_i[1:0],
                           bus.wb_dat_i[31:18], bus.wb_dat_i[15:8]};

   always_comb begin
      has_pending = 1'b0;
      drain_idx   = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (slot_full[i]) begin
            has_pending = 1'b1;
            drain_idx   = 2'(i);
         end
      end
   end

   // Slots hold while disabled; a pop in the same cycle makes room in a full FIFO.
   assign push = en & has_pending & (~fifo_full | pop) & ~flush;

   always_comb begin
      cap      = '0;
      drained  = '0;
      new_drop = '0;
      for (int i = 0; i < 4; i++) begin
         cap[i]      = en & data_valid[i] & ch_mask[i] & ~flush;
         drained[i]  = push && (drain_idx == 2'(i));
         new_drop[i] = cap[i] & slot_full[i] & ~drained[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_full <= '0;
         for (int i = 0; i < 4; i++) slot_data[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (flush) begin
               slot_full[i] <= 1'b0;
            end else if (cap[i]) begin
               slot_full[i] <= 1'b1;
               slot_data[i] <= make_entry(ts, 2'(i), ch_data[i]);
            end else if (drained[i]) begin
               slot_full[i] <= 1'b0;
            end
         end
      end
   end

   sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .clear (flush),
      .wdata (slot_data[drain_idx]),
      .rdata (fifo_rdata),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      rd_mux = '0;
      case (addr)
         REG_CTRL: begin
            rd_mux[CTRL_EN]              = en;
            rd_mux[CTRL_MASK_LSB +: 4]   = ch_mask;
         end
         REG_STATUS: begin
            rd_mux[6:0]                  = 7'(fifo_level);
            rd_mux[ST_EMPTY]             = fifo_empty;
            rd_mux[ST_FULL]              = fifo_full;
            rd_mux[ST_LAST_LSB +: 2]     = last_ch;
         end
         REG_DATA:  rd_mux = fifo_empty ? 32'd0 : fifo_rdata;
         REG_WMARK: rd_mux[6:0] = wmark;
         REG_IRQ: begin
            rd_mux[IRQ_WM_IE]            = wm_ie;
            rd_mux[IRQ_OVF_IE]           = ovf_ie;
            rd_mux[IRQ_WM_ST]            = wm_st;
            rd_mux[IRQ_OVF_ST]           = ovf_st;
         end
         REG_DROP:  rd_mux[3:0] = drop;
         default:   rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.wb_ack_o <= 1'b0;
         bus.wb_dat_o <= '0;
         en           <= 1'b0;
         ch_mask      <= 4'hF;
         wmark        <= 7'(DEPTH / 2);
         wm_ie        <= 1'b0;
         ovf_ie       <= 1'b0;
         wm_st        <= 1'b0;
         ovf_st       <= 1'b0;
         drop         <= '0;
         last_ch      <= '0;
         ts           <= '0;
      end else begin
         bus.wb_ack_o <= bus.wb_cyc_i & bus.wb_stb_i & ~bus.wb_ack_o;
         if (rd) bus.wb_dat_o <= rd_mux;
         if (en) ts <= ts + TS_W'(1);
         if (push) last_ch <= drain_idx;
         // Drops landing in the same cycle as the clearing read must survive it.
         drop   <= ((rd && addr == REG_DROP) ? 4'h0 : drop) | new_drop;
         wm_st  <= (wm_st & ~w1c[0]) | wm_hit;
         ovf_st <= (ovf_st & ~w1c[1]) | (|new_drop);
         if (wr) begin
            case (addr)
               REG_CTRL: begin
                  en      <= bus.wb_dat_i[CTRL_EN];
                  ch_mask <= bus.wb_dat_i[CTRL_MASK_LSB +: 4];
               end
               REG_WMARK: wmark <= bus.wb_dat_i[6:0];
               REG_IRQ: begin
                  wm_ie  <= bus.wb_dat_i[IRQ_WM_IE];
                  ovf_ie <= bus.wb_dat_i[IRQ_OVF_IE];
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adc_sample_buffer.sv
// Directed bench for adc_sample_buffer: capture latency, ordering, watermark, overflow,
// flush, empty pop and asynchronous reset, each step checked against hand-derived values.
module tb_adc_sample_buffer;
   import adc_buf_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] ch0_data, ch1_data, ch2_data, ch3_data;
   logic [3:0]  data_valid;
   logic        irq;
   logic [4:0]  fifo_level;
   logic        en_model;
   logic [13:0] ts_model;
   logic [13:0] exp_ts;
   logic [31:0] rdat;
   int          n_cmp;
   int          n_err;

   adc_sample_buffer_if bus ();

   adc_sample_buffer #(.DEPTH(16), .TS_W(14)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus.slave),
      .ch0_data   (ch0_data),
      .ch1_data   (ch1_data),
      .ch2_data   (ch2_data),
      .ch3_data   (ch3_data),
      .data_valid (data_valid),
      .irq        (irq),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   // Independent timestamp reference: counts each edge while the bench has EN set.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)        ts_model <= '0;
      else if (en_model) ts_model <= ts_model + 14'd1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wb_xfer(input logic we, input logic [2:0] idx, input logic [31:0] wdat,
                          output logic [31:0] rd_val);
      int n;
      if (bus.wb_ack_o) step();
      bus.wb_adr_i = {27'd0, idx, 2'b00};
      bus.wb_dat_i = wdat;
      bus.wb_we_i  = we;
      bus.wb_sel_i = 4'hF;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (!bus.wb_ack_o && n < 8);
      rd_val = bus.wb_dat_o;
      chk("wb_ack", 32'(bus.wb_ack_o), 32'd1);
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
   endtask

   task automatic wb_write(input logic [2:0] idx, input logic [31:0] wdat);
      logic [31:0] dummy;
      wb_xfer(1'b1, idx, wdat, dummy);
   endtask

   task automatic wb_read(input string tag, input logic [2:0] idx, input logic [31:0] exp);
      logic [31:0] v;
      wb_xfer(1'b0, idx, 32'd0, v);
      chk(tag, v, exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish expected finish before 1ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      en_model = 1'b0;
      rst_n = 1'b0;
      {ch0_data, ch1_data, ch2_data, ch3_data} = '0;
      data_valid = '0;
      bus.wb_adr_i = '0;
      bus.wb_dat_i = '0;
      bus.wb_we_i  = 1'b0;
      bus.wb_sel_i = 4'h0;
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;

      // Reset state
      repeat (3) step();
      chk("rst_ack", 32'(bus.wb_ack_o), 32'd0);
      chk("rst_dat", bus.wb_dat_o, 32'd0);
      chk("rst_err", 32'(bus.wb_err_o), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      rst_n = 1'b1;
      step();
      wb_read("rst_ctrl", REG_CTRL, 32'h0000_00F0);
      wb_read("rst_wmark", REG_WMARK, 32'h0000_0008);
      wb_read("rst_status", REG_STATUS, 32'h0000_0100);

      // Single ch0 sample captured at ts=5
      wb_write(REG_CTRL, 32'h0000_00F1);
      en_model = 1'b1;
      repeat (5) step();
      ch0_data = 16'h1234;
      data_valid = 4'b0001;
      step();
      data_valid = 4'b0000;
      chk("lat_t1_level", 32'(fifo_level), 32'd0);
      step();
      chk("lat_t2_level", 32'(fifo_level), 32'd1);
      wb_read("t1_data", REG_DATA, 32'h0014_1234);
      chk("t1_level_after_pop", 32'(fifo_level), 32'd0);

      // Four simultaneous valids drain in channel order with one timestamp
      ch0_data = 16'hA000; ch1_data = 16'hA001; ch2_data = 16'hA002; ch3_data = 16'hA003;
      exp_ts = ts_model;
      data_valid = 4'b1111;
      step();
      data_valid = 4'b0000;
      step();
      chk("burst_level_t2", 32'(fifo_level), 32'd1);
      repeat (3) step();
      chk("burst_level_t5", 32'(fifo_level), 32'd4);
      wb_read("burst_status", REG_STATUS, 32'h0000_0C04);
      for (int k = 0; k < 4; k++)
         wb_read("burst_data", REG_DATA, {exp_ts, 2'(k), 16'hA000 + 16'(k)});
      chk("burst_level_end", 32'(fifo_level), 32'd0);

      // Watermark interrupt at level 3, sticky until write-1-to-clear
      wb_write(REG_WMARK, 32'd3);
      wb_write(REG_IRQ, 32'h0000_0001);
      ch0_data = 16'hB000; ch1_data = 16'hB001; ch2_data = 16'hB002;
      exp_ts = ts_model;
      data_valid = 4'b0111;
      step();
      data_valid = 4'b0000;
      step();
      step();
      chk("wm_irq_level2", 32'(irq), 32'd0);
      step();
      chk("wm_level3", 32'(fifo_level), 32'd3);
      chk("wm_irq_level3", 32'(irq), 32'd1);
      wb_read("wm_pop0", REG_DATA, {exp_ts, 2'd0, 16'hB000});
      chk("wm_level_after_pop", 32'(fifo_level), 32'd2);
      chk("wm_irq_sticky", 32'(irq), 32'd1);
      wb_write(REG_IRQ, 32'h0001_0001);
      chk("wm_irq_cleared", 32'(irq), 32'd0);
      wb_read("wm_irq_reg", REG_IRQ, 32'h0000_0001);
      wb_read("wm_pop1", REG_DATA, {exp_ts, 2'd1, 16'hB001});
      wb_read("wm_pop2", REG_DATA, {exp_ts, 2'd2, 16'hB002});

      // Fill to 16, then overflow on ch2
      wb_write(REG_IRQ, 32'h0000_0002);
      for (int k = 0; k < 16; k++) begin
         ch2_data = 16'hC000 + 16'(k);
         data_valid = 4'b0100;
         step();
      end
      data_valid = 4'b0000;
      step();
      chk("fill_level", 32'(fifo_level), 32'd16);
      chk("fill_irq_quiet", 32'(irq), 32'd0);
      ch2_data = 16'hD000;
      data_valid = 4'b0100;
      step();
      data_valid = 4'b0000;
      step();
      chk("full_hold_level", 32'(fifo_level), 32'd16);
      ch2_data = 16'hD001;
      data_valid = 4'b0100;
      step();
      data_valid = 4'b0000;
      step();
      chk("ovf_irq", 32'(irq), 32'd1);
      wb_read("ovf_drop", REG_DROP, 32'h0000_0004);
      wb_read("ovf_irq_reg", REG_IRQ, 32'h0003_0002);
      wb_read("ovf_drop_cleared", REG_DROP, 32'h0000_0000);
      wb_read("ovf_status", REG_STATUS, 32'h0000_0A10);

      // FLUSH in the same cycle as a ch0 valid
      if (bus.wb_ack_o) step();
      bus.wb_adr_i = {27'd0, REG_CTRL, 2'b00};
      bus.wb_dat_i = 32'h0000_00F3;
      bus.wb_we_i  = 1'b1;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      ch0_data = 16'hEEEE;
      data_valid = 4'b0001;
      step();
      data_valid = 4'b0000;
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      chk("flush_ack", 32'(bus.wb_ack_o), 32'd1);
      chk("flush_level", 32'(fifo_level), 32'd0);
      step();
      step();
      chk("flush_pending_empty", 32'(fifo_level), 32'd0);
      wb_read("flush_sticky", REG_IRQ, 32'h0003_0002);
      wb_read("flush_reads_zero", REG_CTRL, 32'h0000_00F1);
      chk("flush_irq", 32'(irq), 32'd1);

      // Pop on empty FIFO with strobe held across two edges
      if (bus.wb_ack_o) step();
      bus.wb_adr_i = {27'd0, REG_DATA, 2'b00};
      bus.wb_we_i  = 1'b0;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      step();
      chk("empty_ack", 32'(bus.wb_ack_o), 32'd1);
      chk("empty_data", bus.wb_dat_o, 32'd0);
      step();
      chk("ack_one_cycle", 32'(bus.wb_ack_o), 32'd0);
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      chk("empty_level", 32'(fifo_level), 32'd0);

      // Asynchronous reset in the middle of a burst
      wb_read("pre_rst_ctrl", REG_CTRL, 32'h0000_00F1);
      data_valid = 4'b1111;
      step();
      data_valid = 4'b0000;
      step();
      chk("mid_burst_level", 32'(fifo_level), 32'd1);
      rst_n = 1'b0;
      en_model = 1'b0;
      #1;
      chk("arst_level", 32'(fifo_level), 32'd0);
      chk("arst_irq", 32'(irq), 32'd0);
      chk("arst_ack", 32'(bus.wb_ack_o), 32'd0);
      chk("arst_dat", bus.wb_dat_o, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      wb_read("post_rst_ctrl", REG_CTRL, 32'h0000_00F0);
      wb_read("post_rst_status", REG_STATUS, 32'h0000_0100);
      wb_read("post_rst_drop", REG_DROP, 32'h0000_0000);
      repeat (3) step();
      chk("post_rst_level", 32'(fifo_level), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/adc_sample_buffer.md
# adc_sample_buffer

Downstream of the 4-channel Σ-Δ ADC subsystem: captures the per-channel 16-bit filtered samples on their single-cycle `data_valid` pulses, tags each with channel number and a timestamp, and queues them in a FIFO. Software drains the FIFO over Wishbone. A watermark interrupt lets the CPU read bursts instead of servicing every conversion.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries. Power of two, 4..64.
- `TS_W`, 14: timestamp width. Fixed so that `TS_W + 2 + 16 = 32`.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `wb_adr_i`, in, 32: Wishbone address. Only bits [4:2] are decoded.
- `wb_dat_i`, in, 32: write data.
- `wb_dat_o`, out, 32: read data.
- `wb_we_i`, in, 1: write enable.
- `wb_sel_i`, in, 4: byte select. Ignored; all accesses are full-word.
- `wb_cyc_i`, in, 1: bus cycle.
- `wb_stb_i`, in, 1: strobe.
- `wb_ack_o`, out, 1: acknowledge.
- `wb_err_o`, out, 1: error. Tied to 0.
- `ch0_data`..`ch3_data`, in, 16 each: filtered samples.
- `data_valid`, in, 4: one-cycle pulse per channel, bit i qualifies `chi_data`.
- `irq`, out, 1: level interrupt.
- `fifo_level`, out, $clog2(DEPTH)+1: current entry count.

## Operation
Registers:
- **0x00 CTRL**, RW.
  - [0] EN.
  - [1] FLUSH: write 1 to flush; reads as 0.
  - [7:4] CH_MASK: 1 = accept that channel.
  - Reset value 0x0000_00F0.
- **0x04 STATUS**, RO.
  - [6:0] level.
  - [8] empty, [9] full.
  - [11:10] last channel written.
- **0x08 DATA**, RO, pop on read.
  - Entry format: {ts[13:0], ch[1:0], data[15:0]}.
- **0x0C WMARK**, RW, [6:0]. Reset value DEPTH/2.
- **0x10 IRQ**, bits [1:0].
  - [0] WM_IE, [1] OVF_IE.
  - [17:16] WM_ST, OVF_ST. Sticky, write-1-to-clear.
- **0x14 DROP**, RO. [3:0] per-channel sticky drop flags, cleared on read.

Capture:
- When EN=1 and `data_valid[i]` & CH_MASK[i], load pending slot i with {ts, i, `chi_data`}.
- If slot i is already full, overwrite it, set DROP[i] and OVF_ST.
- EN=0: valids are ignored, the timestamp counter freezes, pending slots are held.

Drain:
- Each cycle, the lowest-index full pending slot is written to the FIFO if the FIFO is not full, or if a pop happens in the same cycle.
- At most one write per cycle.
- Up to 4 simultaneous valids drain over 4 consecutive cycles.

Timestamp:
- `TS_W`-bit free-running counter, +1 per clk while EN=1.
- Wraps 0x3FFF → 0.

Pop:
- A DATA read returns the head entry and advances the read pointer.
- Pop when empty returns 0x0000_0000 with no pointer change.

Simultaneous push and pop: level is unchanged and both pointers advance.

Interrupt conditions:
- WM_ST is set on every cycle where level >= WMARK and WMARK != 0.
- WMARK = 0 disables the watermark interrupt.
- `irq` = (WM_ST & WM_IE) | (OVF_ST & OVF_IE).

FLUSH:
- Clears both pointers, the level and all pending slots within one cycle.
- Does not clear sticky flags.
- A capture in the same cycle as FLUSH is discarded.

## Timing
Reset values:
- `wb_ack_o` = 0, `wb_dat_o` = 0, `irq` = 0, `fifo_level` = 0.
- Pending slots empty, timestamp = 0.

Wishbone:
- `wb_ack_o` rises one cycle after cyc&stb and lasts exactly one cycle: ack <= cyc & stb & ~ack.
- Read data is registered in the same edge that raises ack.
- A pop happens exactly once per read transaction, at that edge, even if stb is held.

Capture-to-FIFO latency:
- Valid in cycle t → pending at edge t+1 → FIFO write at edge t+2, if this is the highest-priority slot and there is space.
- `fifo_level` and STATUS reflect the new entry from cycle t+2.

Full FIFO:
- Pending slots hold; no FIFO write occurs.
- Further captures into a held slot are drops.

Reset mid-operation: all state is discarded asynchronously.

## Structure
- Package `adc_buf_pkg` holds:
  - register offset localparams;
  - entry field positions TS_LSB=18, CH_LSB=16;
  - CTRL/IRQ bit indices.
- Sub-module `sync_fifo` (params WIDTH, DEPTH):
  - ports: push, pop, wdata, rdata, level, full, empty, clear;
  - extra MSB on pointers to distinguish full from empty.
- Top level holds the register file, pending slots and priority drain.

## Test plan
- EN=1; pulse `data_valid`=4'b0001 with ch0=0x1234 at ts=5 → level=1 at t+2; DATA read returns 0x0014_1234; level returns to 0.
- `data_valid`=4'b1111 in one cycle → four writes on consecutive cycles in order ch0..ch3; DATA reads return ch fields 0,1,2,3 with identical ts.
- Fill to DEPTH=16, then 2 more ch2 valids → full=1; DROP=0x4; OVF_ST=1; `irq`=1 with OVF_IE=1; a DROP read clears DROP to 0.
- WMARK=3, WM_IE=1; push 3 samples → `irq` rises the cycle level=3; pop 1 → `irq` stays set (sticky); write 1<<16 to IRQ → `irq`=0.
- DATA read on empty FIFO → returns 0; level stays 0; ack lasts one cycle with stb held 3 cycles.
- FLUSH coincident with a valid pulse → level=0, pending empty, sticky flags unchanged; reset asserted mid-burst → all outputs return to their reset values.
